// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the instruction-fetch sequencer: state codes,
// the two locally executed opcodes and the Moore control decode.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_LATCH  = 3'd2,
    S_JADDR  = 3'd3,
    S_JLOAD  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [3:0] OP_JMP = 4'hF;
  localparam logic [3:0] OP_HLT = 4'hE;

  typedef struct packed {
    logic pc_l;
    logic pc_e;
    logic fetch_e;
    logic busy;
    logic halted;
  } ctrl_t;

  // Control levels that belong to a state; depend on nothing but the state.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_ADDR:   c.busy = 1'b1;
      S_LATCH:  begin
        c.busy    = 1'b1;
        c.fetch_e = 1'b1;
        c.pc_e    = 1'b1;
      end
      S_JADDR:  c.busy = 1'b1;
      S_JLOAD:  begin
        c.busy = 1'b1;
        c.pc_l = 1'b1;
      end
      S_HALTED: c.halted = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: drives the program counter and fetch
// register, executes two-byte jumps and HLT locally, and strobes every
// other instruction byte downstream.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        R,
  input  logic        start,
  input  logic        halt_req,
  input  logic [7:0]  instr,
  output logic        pc_L,
  output logic        pc_E,
  output logic [11:0] pc_D,
  output logic        fetch_E,
  output logic [7:0]  ir,
  output logic        instr_valid,
  output logic        busy,
  output logic        halted
);

  state_t     state;
  state_t     state_nx;
  logic       halt_pend;
  logic       pend_now;
  logic [3:0] jmp_nib;
  ctrl_t      ctrl_nx;

  // Next-state decode; a halt request arriving in the current busy cycle
  // already counts for the instruction boundary at the end of this cycle.
  always_comb begin
    pend_now = halt_pend | (halt_req & busy);
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_ADDR;
      S_ADDR:   state_nx = S_LATCH;
      S_LATCH: begin
        if (instr[7:4] == OP_JMP)      state_nx = S_JADDR;
        else if (instr[7:4] == OP_HLT) state_nx = S_HALTED;
        else                           state_nx = pend_now ? S_IDLE : S_ADDR;
      end
      S_JADDR:  state_nx = S_JLOAD;
      S_JLOAD:  state_nx = pend_now ? S_IDLE : S_ADDR;
      S_HALTED: if (start) state_nx = S_ADDR;
      default:  state_nx = S_IDLE;
    endcase
    ctrl_nx = ctrl_for(state_nx);
  end

  // State register with registered Moore controls, so pc_L never glitches
  // into the counter's asynchronous load.
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state       <= S_IDLE;
      pc_L        <= 1'b0;
      pc_E        <= 1'b0;
      fetch_E     <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      halt_pend   <= 1'b0;
      jmp_nib     <= 4'h0;
      pc_D        <= 12'h000;
      ir          <= 8'h00;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      pc_L        <= ctrl_nx.pc_l;
      pc_E        <= ctrl_nx.pc_e;
      fetch_E     <= ctrl_nx.fetch_e;
      busy        <= ctrl_nx.busy;
      halted      <= ctrl_nx.halted;
      instr_valid <= 1'b0;

      if (state_nx == S_IDLE)   halt_pend <= 1'b0;
      else if (halt_req & busy) halt_pend <= 1'b1;

      case (state)
        S_LATCH: begin
          if (instr[7:4] == OP_JMP) begin
            jmp_nib <= instr[3:0];
          end else if (instr[7:4] != OP_HLT) begin
            ir          <= instr;
            instr_valid <= 1'b1;
          end
        end
        S_JADDR: pc_D <= {jmp_nib, instr};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: counter + ROM around the DUT, directed
// scenarios on a fixed image, then random ROMs against a program-level model.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        CLK = 1'b0;
  logic        R = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [7:0]  instr;
  logic        pc_L, pc_E, fetch_E, instr_valid, busy, halted;
  logic [11:0] pc_D;
  logic [7:0]  ir;

  logic [7:0]  rom [0:4095];
  logic [11:0] cnt;
  logic [11:0] pc;
  logic        pre_en = 1'b0;
  logic [11:0] pre_val = 12'h000;

  int errors = 0;
  int checks = 0;
  int n_strobe = 0;
  int n_load = 0;
  int n_overlap = 0;

  fetch_sequencer dut (
    .CLK(CLK), .R(R), .start(start), .halt_req(halt_req), .instr(instr),
    .pc_L(pc_L), .pc_E(pc_E), .pc_D(pc_D), .fetch_E(fetch_E), .ir(ir),
    .instr_valid(instr_valid), .busy(busy), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // Program counter: async reset, async load (seen through pc), increment.
  always_ff @(posedge CLK or posedge R) begin
    if (R)           cnt <= 12'h000;
    else if (pre_en) cnt <= pre_val;
    else if (pc_L)   cnt <= pc_D;
    else if (pc_E)   cnt <= cnt + 12'd1;
  end
  assign pc    = pc_L ? pc_D : cnt;
  assign instr = rom[pc];

  // Event counters sampled at the end of each cycle.
  always @(posedge CLK) begin
    if (instr_valid) n_strobe++;
    if (pc_L) n_load++;
    if (pc_L && pc_E) n_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pc_L"}, pc_L, 0);
    chk({tag, "_pc_E"}, pc_E, 0);
    chk({tag, "_fetch_E"}, fetch_E, 0);
    chk({tag, "_pc_D"}, pc_D, 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_pc"}, pc, 0);
  endtask

  task automatic do_reset(input string tag);
    R = 1'b1; start = 1'b0; halt_req = 1'b0;
    #1;
    check_zero(tag);
    step(2);
    R = 1'b0;
  endtask

  task automatic load_image();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h12; rom[12'h001] = 8'h34; rom[12'h002] = 8'hF1;
    rom[12'h003] = 8'h00; rom[12'h100] = 8'h56; rom[12'h101] = 8'hE0;
    rom[12'h102] = 8'h78;
  endtask

  // Leaves the bench at the negedge of the first ADDR cycle.
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // which: 0 = instr_valid, 1 = pc_L. Returns negedges waited.
  task automatic wait_for(input string tag, input int which, input int budget, output int w);
    w = 0;
    while (!(which == 0 ? instr_valid : pc_L) && w < budget) begin
      step(1);
      w++;
    end
    if (!(which == 0 ? instr_valid : pc_L)) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int base_s, base_l, w, t, halt_t;
    logic [11:0] p;
    logic [7:0]  b;
    logic [7:0]  q_b[$];
    int          q_t[$];
    localparam int N = 120;

    load_image();
    step(1);

    // Straight-line fetch, jump, halt, resume.
    do_reset("rst0");
    base_s = n_strobe; base_l = n_load;
    pulse_start();
    chk("s1_busy", busy, 1);
    step(1);
    chk("s1_fetch_E", fetch_E, 1);
    chk("s1_pc_E", pc_E, 1);
    chk("s1_pc0", pc, 12'h000);
    step(1);
    chk("s1_v12", instr_valid, 1);
    chk("s1_ir12", ir, 8'h12);
    step(1);
    chk("s1_v_drop", instr_valid, 0);
    step(1);
    chk("s1_v34", instr_valid, 1);
    chk("s1_ir34", ir, 8'h34);
    step(2);
    chk("s1_jaddr_pc", pc, 12'h003);
    chk("s1_jaddr_busy", busy, 1);
    chk("s1_jaddr_pcL", pc_L, 0);
    step(1);
    chk("s1_jload_pcL", pc_L, 1);
    chk("s1_jload_pc", pc, 12'h100);
    chk("s1_jload_pcE", pc_E, 0);
    step(3);
    chk("s1_v56", instr_valid, 1);
    chk("s1_ir56", ir, 8'h56);
    step(2);
    chk("s1_halted", halted, 1);
    chk("s1_halt_busy", busy, 0);
    chk("s1_halt_pc", pc, 12'h102);
    chk("s1_strobes", n_strobe - base_s, 3);
    chk("s1_loads", n_load - base_l, 1);
    pulse_start();
    chk("s1_resume_halted", halted, 0);
    wait_for("s1_resume", 0, 8, w);
    chk("s1_resume_lat", w, 2);
    chk("s1_ir78", ir, 8'h78);

    // halt_req during LATCH of 0x34.
    do_reset("rst1");
    base_s = n_strobe;
    pulse_start();
    step(2);
    chk("s2_ir12", ir, 8'h12);
    step(1);
    halt_req = 1'b1;
    chk("s2_latch", fetch_E, 1);
    step(1);
    halt_req = 1'b0;
    chk("s2_v34", instr_valid, 1);
    chk("s2_ir34", ir, 8'h34);
    chk("s2_idle_busy", busy, 0);
    step(6);
    chk("s2_strobes", n_strobe - base_s, 2);
    chk("s2_busy_end", busy, 0);
    chk("s2_pc_end", pc, 12'h002);

    // halt_req during JADDR: jump completes, then idle.
    do_reset("rst2");
    base_s = n_strobe;
    pulse_start();
    step(6);
    halt_req = 1'b1;
    chk("s3_jaddr_busy", busy, 1);
    step(1);
    halt_req = 1'b0;
    chk("s3_pcL", pc_L, 1);
    chk("s3_pc", pc, 12'h100);
    step(1);
    chk("s3_idle", busy, 0);
    chk("s3_pc_hold", pc, 12'h100);
    chk("s3_pcL_drop", pc_L, 0);
    step(5);
    chk("s3_strobes", n_strobe - base_s, 2);
    chk("s3_busy_end", busy, 0);

    // Reset in the middle of JADDR.
    do_reset("rst3");
    pulse_start();
    step(6);
    chk("s4_jaddr", pc, 12'h003);
    R = 1'b1;
    #1;
    check_zero("s4_mid");
    step(1);
    R = 1'b0;
    pulse_start();
    wait_for("s4_refetch", 0, 8, w);
    chk("s4_ir12", ir, 8'h12);

    // Jump at 0xFFF takes its low byte from 0x000.
    rom[12'hFFF] = 8'hF2;
    rom[12'h000] = 8'h34;
    do_reset("rst4");
    pre_val = 12'hFFF; pre_en = 1'b1;
    step(1);
    pre_en = 1'b0;
    chk("s5_preload", pc, 12'hFFF);
    pulse_start();
    wait_for("s5_load", 1, 10, w);
    chk("s5_pc", pc, 12'h234);
    chk("s5_pc_D", pc_D, 12'h234);

    // Random ROM images checked against a program-level walk.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
      do_reset("rrst");
      pre_val = 12'($urandom); pre_en = 1'b1;
      step(1);
      pre_en = 1'b0;

      q_b.delete(); q_t.delete();
      p = pre_val; t = 0; halt_t = -1;
      while (t + 3 <= N) begin
        b = rom[p];
        if (b[7:4] == OP_JMP) begin
          p = {b[3:0], rom[p + 12'd1]};
          t += 4;
        end else if (b[7:4] == OP_HLT) begin
          halt_t = t + 3;
          break;
        end else begin
          q_b.push_back(b);
          q_t.push_back(t + 3);
          p = p + 12'd1;
          t += 2;
        end
      end

      start = 1'b1;
      for (int c = 1; c <= N; c++) begin
        step(1);
        start = 1'b0;
        chk("rnd_overlap", pc_L & pc_E, 0);
        if (c == halt_t) chk("rnd_halted", halted, 1);
        if (instr_valid) begin
          if (q_b.size() == 0) begin
            chk("rnd_extra_strobe", c, 0);
          end else begin
            chk("rnd_byte", ir, q_b.pop_front());
            chk("rnd_time", c, q_t.pop_front());
          end
        end
      end
      chk("rnd_missing", q_b.size(), 0);
    end

    chk("overlap_total", n_overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
